arashi_mem_rr: RTL and testbench

- Parametrised successor of the per-thread cache-to-thread read buffer.
- A single shared FIFO is filled from the cache side and drained to THREAD_NUM threads through a built-in round-robin arbiter.
- Adds the following over the previous generation:
  - valid/ready backpressure on the write side;
  - full-depth usage (all 2^MEM_WIDTH entries);
  - any THREAD_NUM_WIDTH;
  - occupancy and status flags.
- Sits between the cache return path and the thread pipelines.

---
 rtl/arashi_mem_pkg.sv | 22 ++
 rtl/arashi_rr_arbiter.sv | 43 ++++
 rtl/arashi_mem_rr.sv | 88 ++++++++
 tb/tb_arashi_mem_rr.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arashi_mem_pkg.sv
// Shared sizing helpers and types for the arashi cache-to-thread read FIFO.
package arashi_mem_pkg;

  localparam int MAX_THREADS   = 256;
  localparam int DEF_MEM_WIDTH = 4;

  // Pointer type for the default depth; carries one extra wrap bit.
  typedef logic [DEF_MEM_WIDTH:0] ptr_t;

  function automatic int thread_num(input int tw);
    return 1 << tw;
  endfunction

  function automatic int depth(input int mw);
    return 1 << mw;
  endfunction

  function automatic logic [MAX_THREADS-1:0] onehot(input int unsigned id);
    return {{(MAX_THREADS-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/arashi_rr_arbiter.sv
// Round-robin arbiter: first requester at or above rr_ptr wins, with wrap.
module arashi_rr_arbiter
  import arashi_mem_pkg::*;
#(
  parameter int THREAD_NUM_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0]    req,
  input  logic                                en,
  output logic                                gnt_valid,
  output logic [THREAD_NUM_WIDTH-1:0]         gnt_id
);

  localparam int N = thread_num(THREAD_NUM_WIDTH);

  logic [THREAD_NUM_WIDTH-1:0] rr_ptr_q, rr_ptr_d, idx;

  // Scan downward so the smallest offset from rr_ptr is the final winner.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = rr_ptr_q;
    for (int i = N-1; i >= 0; i--) begin
      idx = rr_ptr_q + THREAD_NUM_WIDTH'(i);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (en && gnt_valid) rr_ptr_d = gnt_id + THREAD_NUM_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/arashi_mem_rr.sv
// Shared FIFO filled from the cache side, drained to threads round-robin.
module arashi_mem_rr
  import arashi_mem_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int MEM_WIDTH        = 4,
  parameter int AFULL_THRESH     = (1 << MEM_WIDTH) - 2
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            wr_valid,
  input  logic [DATA_WIDTH-1:0]                           wr_data,
  output logic                                            wr_ready,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0]                r_ena,
  output logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0]     data_out,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]                r_ready,
  output logic [MEM_WIDTH:0]                              count,
  output logic                                            empty,
  output logic                                            full,
  output logic                                            almost_full
);

  localparam int                 THREAD_NUM = thread_num(THREAD_NUM_WIDTH);
  localparam int                 DEPTH      = depth(MEM_WIDTH);
  localparam logic [MEM_WIDTH:0] AFULL      = (MEM_WIDTH+1)'(AFULL_THRESH);
  localparam logic [MEM_WIDTH:0] PTR_ONE    = (MEM_WIDTH+1)'(1);

  logic [MEM_WIDTH:0]                         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0]                      mem [DEPTH];
  logic [THREAD_NUM-1:0][DATA_WIDTH-1:0]      data_out_q, data_out_d;
  logic [THREAD_NUM-1:0]                      r_ready_q, r_ready_d;
  logic                                       gnt_valid, rd_en, wr_fire, rd_fire;
  logic [THREAD_NUM_WIDTH-1:0]                gnt_id;

  // Extra pointer MSB distinguishes full from empty so all DEPTH entries are usable.
  assign count       = wptr_q - rptr_q;
  assign empty       = (wptr_q == rptr_q);
  assign full        = (wptr_q[MEM_WIDTH] != rptr_q[MEM_WIDTH]) &&
                       (wptr_q[MEM_WIDTH-1:0] == rptr_q[MEM_WIDTH-1:0]);
  assign almost_full = (count >= AFULL);
  assign wr_ready    = !rst && !full;
  assign wr_fire     = wr_valid && wr_ready;
  assign rd_en       = !empty;
  assign rd_fire     = gnt_valid && rd_en;
  assign data_out    = data_out_q;
  assign r_ready     = r_ready_q;

  arashi_rr_arbiter #(.THREAD_NUM_WIDTH(THREAD_NUM_WIDTH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (r_ena),
    .en        (rd_en),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Read uses the pre-edge rptr/wptr, so a word written this edge is not visible yet.
  always_comb begin
    wptr_d     = wr_fire ? wptr_q + PTR_ONE : wptr_q;
    rptr_d     = rd_fire ? rptr_q + PTR_ONE : rptr_q;
    data_out_d = data_out_q;
    r_ready_d  = '0;
    if (rd_fire) begin
      data_out_d[gnt_id] = mem[rptr_q[MEM_WIDTH-1:0]];
      r_ready_d          = THREAD_NUM'(onehot(32'(gnt_id)));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wptr_q[MEM_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      data_out_q <= '0;
      r_ready_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      data_out_q <= data_out_d;
      r_ready_q  <= r_ready_d;
    end
  end

endmodule

// File: tb/tb_arashi_mem_rr.sv
// Self-checking bench for arashi_mem_rr against a queue-based reference model.
module tb_arashi_mem_rr;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid = 1'b0;
  logic [31:0]  wr_data = '0;
  logic [3:0]   r_ena = '0;
  logic         wr_ready;
  logic [127:0] data_out;
  logic [3:0]   r_ready;
  logic [4:0]   count;
  logic         empty, full, almost_full;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain queue, round-robin pointer, per-thread slot copies.
  logic [31:0] mq[$];
  logic [31:0] m_slot[4];
  int          m_rr;
  logic [3:0]  m_rready;
  bit          m_acc;

  arashi_mem_rr dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .r_ena(r_ena), .data_out(data_out), .r_ready(r_ready), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] slot(input int t);
    return data_out[t*32 +: 32];
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int t = 0; t < 4; t++) m_slot[t] = '0;
    m_rr = 0;
    m_rready = '0;
    m_acc = 0;
  endtask

  // Drive one cycle at the negedge, update the model at the posedge, return 1 time unit later.
  task automatic step(input logic wv, input logic [31:0] wd, input logic [3:0] re);
    bit gf;
    int g;
    @(negedge clk);
    wr_valid = wv; wr_data = wd; r_ena = re;
    @(posedge clk);
    gf = 0; g = 0;
    m_acc = wv && (mq.size() < 16);
    if (mq.size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        int t;
        t = (m_rr + k) % 4;
        if (!gf && re[t]) begin gf = 1; g = t; end
      end
    end
    if (gf) begin
      m_slot[g] = mq.pop_front();
      m_rr = (g + 1) % 4;
      m_rready = 4'b0001 << g;
    end else begin
      m_rready = '0;
    end
    if (m_acc) mq.push_back(wd);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b0; r_ena = '0;
    #1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    #2;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_err++; $display("FAIL reset_flags: full %b af %b want 0 0", full, almost_full); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready_in_rst: got %b want 0", wr_ready); end
    n_cmp++; if (r_ready !== 4'b0) begin n_err++; $display("FAIL reset_r_ready: got %b want 0", r_ready); end
    n_cmp++; if (data_out !== 128'b0) begin n_err++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL idle_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_fill();
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h100 + i, 4'b0);
      n_cmp++; if (count !== 5'(i+1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i+1); end
      n_cmp++; if (almost_full !== (i+1 >= 14)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, (i+1 >= 14)); end
      n_cmp++; if (full !== (i == 15)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 15)); end
    end
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fill_wr_ready: got %b want 0", wr_ready); end
    step(1'b1, 32'h1FF, 4'b0);
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_17th_count: got %0d want 16", count); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 4'b0001);
      n_cmp++; if (slot(0) !== 32'h100 + i) begin n_err++; $display("FAIL fill_drain[%0d]: got %h want %h", i, slot(0), 32'h100 + i); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_drained_empty: got %b want 1", empty); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int i = 0; i < 5; i++) step(1'b1, 32'hAAAA_0000 + i, 4'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 4'b1111);
      n_cmp++; if (r_ready !== (4'b0001 << (i % 4))) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, r_ready, 4'b0001 << (i % 4)); end
      n_cmp++; if (slot(i % 4) !== 32'hAAAA_0000 + i) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", i, slot(i % 4), 32'hAAAA_0000 + i); end
    end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL rr_count: got %0d want 0", count); end
  endtask

  task automatic test_skip();
    int exp_t[3] = '{1, 3, 1};
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5500 + i, 4'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 4'b1010);
      n_cmp++; if (r_ready !== (4'b0001 << exp_t[i])) begin n_err++; $display("FAIL skip_ready[%0d]: got %b want %b", i, r_ready, 4'b0001 << exp_t[i]); end
      n_cmp++; if (slot(exp_t[i]) !== 32'h5500 + i) begin n_err++; $display("FAIL skip_data[%0d]: got %h want %h", i, slot(exp_t[i]), 32'h5500 + i); end
    end
    n_cmp++; if (slot(0) !== 32'h0 || slot(2) !== 32'h0) begin n_err++; $display("FAIL skip_hold: slot0 %h slot2 %h want 0 0", slot(0), slot(2)); end
  endtask

  task automatic test_full_concurrent();
    reset_dut();
    for (int i = 0; i < 16; i++) step(1'b1, 32'h200 + i, 4'b0);
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fullrd_pre_wr_ready: got %b want 0", wr_ready); end
    step(1'b1, 32'hF00D, 4'b0100);
    n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL fullrd_c1_count: got %0d want 15", count); end
    n_cmp++; if (r_ready !== 4'b0100 || slot(2) !== 32'h200) begin n_err++; $display("FAIL fullrd_c1_read: rdy %b data %h want 0100 200", r_ready, slot(2)); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fullrd_c2_wr_ready: got %b want 1", wr_ready); end
    step(1'b1, 32'hF00D, 4'b0100);
    n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL fullrd_c2_count: got %0d want 15", count); end
    n_cmp++; if (slot(2) !== 32'h201) begin n_err++; $display("FAIL fullrd_c2_data: got %h want 201", slot(2)); end
  endtask

  task automatic test_wrap_random();
    int wi = 0, ri = 0, cyc = 0;
    logic wv;
    reset_dut();
    while (ri < 40 && cyc < 3000) begin
      wv = (wi < 40) && ($urandom_range(0, 1) == 1);
      step(wv, 32'hB000 + wi, 4'($urandom_range(0, 15)));
      cyc++;
      if (m_acc) wi++;
      n_cmp++; if (r_ready !== m_rready) begin n_err++; $display("FAIL wrap_ready[c%0d]: got %b want %b", cyc, r_ready, m_rready); end
      n_cmp++; if (count !== 5'(mq.size()) || count > 5'd16) begin n_err++; $display("FAIL wrap_count[c%0d]: got %0d want %0d", cyc, count, mq.size()); end
      for (int t = 0; t < 4; t++) begin
        if (r_ready[t]) begin
          n_cmp++; if (slot(t) !== 32'hB000 + ri) begin n_err++; $display("FAIL wrap_order[%0d]: got %h want %h", ri, slot(t), 32'hB000 + ri); end
          ri++;
        end
      end
    end
    n_cmp++; if (ri != 40) begin n_err++; $display("FAIL wrap_budget: got %0d words want 40", ri); end
    step(1'b1, 32'hC0DE, 4'b1111);
    n_cmp++; if (r_ready !== 4'b0) begin n_err++; $display("FAIL nobypass_same: got %b want 0000", r_ready); end
    step(1'b0, '0, 4'b1111);
    n_cmp++; if (r_ready !== m_rready || m_rready == 4'b0) begin n_err++; $display("FAIL nobypass_next: got %b want %b", r_ready, m_rready); end
    for (int t = 0; t < 4; t++) begin
      if (m_rready[t]) begin
        n_cmp++; if (slot(t) !== 32'hC0DE) begin n_err++; $display("FAIL nobypass_data: got %h want c0de", slot(t)); end
      end
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    for (int i = 0; i < 6; i++) step(1'b1, 32'h3300 + i, 4'b0);
    step(1'b0, '0, 4'b0001);
    n_cmp++; if (r_ready !== 4'b0001 || count !== 5'd5) begin n_err++; $display("FAIL midrst_pre: rdy %b count %0d want 0001 5", r_ready, count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL midrst_count: got %0d want 0", count); end
    n_cmp++; if (r_ready !== 4'b0) begin n_err++; $display("FAIL midrst_r_ready: got %b want 0", r_ready); end
    n_cmp++; if (data_out !== 128'b0) begin n_err++; $display("FAIL midrst_data_out: got %h want 0", data_out); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h77, 4'b0);
    step(1'b0, '0, 4'b1111);
    n_cmp++; if (r_ready !== 4'b0001 || slot(0) !== 32'h77) begin n_err++; $display("FAIL midrst_prio: rdy %b data %h want 0001 77", r_ready, slot(0)); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_round_robin();
    test_skip();
    test_full_concurrent();
    test_wrap_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
